keypad_scan_debounce: RTL and testbench

//   Parametrised matrix-keypad front end: scans ROWS x COLS keypad, debounces full-frame

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/column_scanner.sv | 60 ++++++
 rtl/keypad_scan_debounce.sv | 121 ++++++++++++
 tb/tb_keypad_scan_debounce.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix-keypad front end: FSM states,
// default 50 MHz timing constants and small bit-vector helpers.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN  = 2'd0,
      HELD  = 2'd1,
      BLOCK = 2'd2
   } state_t;

   // Widest keypad the helper functions accept (ROWS*COLS must not exceed this)
   localparam int MAX_KEYS = 64;

   // 50 MHz defaults: 16 clocks column settle, 10 ms debounce window
   localparam int DEF_SETTLE_CYC   = 16;
   localparam int DEF_DEBOUNCE_CYC = 500000;

   // Number of closed keys in a frame snapshot
   function automatic int unsigned popcount(input logic [MAX_KEYS-1:0] v);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < MAX_KEYS; i++) begin
         if (v[i]) cnt++;
      end
      return cnt;
   endfunction

   // Bit position of the single set bit; only meaningful when popcount(v)==1
   function automatic int unsigned onehot_index(input logic [MAX_KEYS-1:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_KEYS; i++) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/column_scanner.sv
// Free-running column scanner: drives one column low at a time, lets the
// lines settle, captures the active-low rows into a full-frame snapshot and
// flags the cycle after the last column of a frame has been captured.
module column_scanner #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SETTLE_CYC = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ROWS-1:0]      rows,
   output logic [COLS-1:0]      columns,
   output logic [ROWS*COLS-1:0] snap,
   output logic                 frame_done
);

   localparam int COL_W = $clog2(COLS);
   localparam int SET_W = $clog2(SETTLE_CYC + 1);

   logic [COL_W-1:0] col_idx;
   logic [COL_W-1:0] next_col;
   logic [SET_W-1:0] settle_cnt;

   // One-hot-low column drive pattern for a given column index
   function automatic logic [COLS-1:0] drive(input logic [COL_W-1:0] idx);
      return ~(COLS'(1) << idx);
   endfunction

   // Column that follows the current one, wrapping after the last column
   always_comb begin
      next_col = col_idx + COL_W'(1);
      if (col_idx == COL_W'(COLS - 1)) next_col = '0;
   end

   // Hold each column low for SETTLE_CYC clocks, then sample its rows and move on
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         columns    <= '1;
         col_idx    <= '0;
         settle_cnt <= '0;
         snap       <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (settle_cnt == SET_W'(SETTLE_CYC)) begin
            for (int c = 0; c < COLS; c++) begin
               if (col_idx == COL_W'(c)) snap[c*ROWS +: ROWS] <= ~rows;
            end
            frame_done <= (col_idx == COL_W'(COLS - 1));
            col_idx    <= next_col;
            settle_cnt <= SET_W'(1);
            columns    <= drive(next_col);
         end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
            columns    <= drive(col_idx);
         end
      end
   end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix-keypad front end: scans the keypad, debounces whole-frame snapshots
// and reports single-key press/release events with a binary key code.
// Frames with several keys closed are flagged and ignored until all keys open.
module keypad_scan_debounce
   import keypad_pkg::*;
#(
   parameter  int ROWS         = 4,
   parameter  int COLS         = 4,
   parameter  int SETTLE_CYC   = DEF_SETTLE_CYC,
   parameter  int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   localparam int CODE_W       = $clog2(ROWS * COLS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ROWS-1:0]   rows,
   output logic [COLS-1:0]   columns,
   output logic              key_valid,
   output logic              key_release,
   output logic [CODE_W-1:0] key_code,
   output logic              key_held,
   output logic              multi_key
);

   localparam int KEYS   = ROWS * COLS;
   localparam int FRAME  = COLS * SETTLE_CYC;
   localparam int STAB_W = $clog2(DEBOUNCE_CYC + FRAME + 1);

   logic [KEYS-1:0]     snap;
   logic [KEYS-1:0]     prev;
   logic                frame_done;
   logic [STAB_W-1:0]   stab_cnt;
   logic                stable;
   logic                release_fire;
   logic [KEYS-1:0]     held_mask;
   logic [MAX_KEYS-1:0] prev_ext;
   int unsigned         prev_pop;
   state_t              state;

   column_scanner #(
      .ROWS       (ROWS),
      .COLS       (COLS),
      .SETTLE_CYC (SETTLE_CYC)
   ) u_scanner (
      .clk        (clk),
      .rst_n      (rst_n),
      .rows       (rows),
      .columns    (columns),
      .snap       (snap),
      .frame_done (frame_done)
   );

   assign prev_ext     = MAX_KEYS'(prev);
   assign prev_pop     = popcount(prev_ext);
   assign held_mask    = KEYS'(1) << key_code;
   assign stable       = (stab_cnt >= STAB_W'(DEBOUNCE_CYC));
   assign release_fire = (state == HELD) && stable && (prev != held_mask);

   // Track how long the frame snapshot has stayed unchanged; a release restarts
   // the window so the next key always needs a full debounce of its own
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stab_cnt <= '0;
         prev     <= '0;
      end else begin
         if (frame_done) begin
            if (snap != prev) begin
               stab_cnt <= '0;
               prev     <= snap;
            end else if (stab_cnt + STAB_W'(FRAME) >= STAB_W'(DEBOUNCE_CYC)) begin
               stab_cnt <= STAB_W'(DEBOUNCE_CYC);
            end else begin
               stab_cnt <= stab_cnt + STAB_W'(FRAME);
            end
         end
         if (release_fire) stab_cnt <= '0;
      end
   end

   // Key state machine turning stable snapshots into one-cycle events
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= SCAN;
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         multi_key   <= 1'b0;
         key_held    <= 1'b0;
         key_code    <= '0;
      end else begin
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         multi_key   <= 1'b0;
         case (state)
            SCAN: begin
               if (stable && (prev != '0)) begin
                  if (prev_pop == 1) begin
                     key_code  <= CODE_W'(onehot_index(prev_ext));
                     key_valid <= 1'b1;
                     key_held  <= 1'b1;
                     state     <= HELD;
                  end else begin
                     multi_key <= 1'b1;
                     state     <= BLOCK;
                  end
               end
            end
            HELD: begin
               if (release_fire) begin
                  key_release <= 1'b1;
                  key_held    <= 1'b0;
                  state       <= SCAN;
               end
            end
            BLOCK: begin
               if (stable && (prev == '0)) state <= SCAN;
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench for keypad_scan_debounce: a keypad matrix model drives
// the rows, and an event-level reference model predicts press/release/multi
// events from the sequence of held key sets.
module tb_keypad_scan_debounce;

   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int CODE_W = 4;
   localparam int LONG   = 200;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ROWS-1:0]   rows;
   logic [COLS-1:0]   columns;
   logic              key_valid;
   logic              key_release;
   logic [CODE_W-1:0] key_code;
   logic              key_held;
   logic              multi_key;

   logic [15:0] keys = '0;
   logic [15:0] cur_keys = '0;

   int checks = 0;
   int fails  = 0;

   logic [7:0] dut_q[$];
   logic [7:0] exp_q[$];

   int held_key  = -1;
   bit blocked   = 1'b0;
   int last_code = 0;

   always #5 clk = ~clk;

   keypad_scan_debounce #(
      .ROWS         (ROWS),
      .COLS         (COLS),
      .SETTLE_CYC   (2),
      .DEBOUNCE_CYC (64)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rows        (rows),
      .columns     (columns),
      .key_valid   (key_valid),
      .key_release (key_release),
      .key_code    (key_code),
      .key_held    (key_held),
      .multi_key   (multi_key)
   );

   // Keypad matrix: a closed key pulls its row low while its column is driven low
   always_comb begin
      rows = '1;
      for (int c = 0; c < COLS; c++) begin
         if (!columns[c]) begin
            for (int r = 0; r < ROWS; r++) begin
               if (keys[c*ROWS + r]) rows[r] = 1'b0;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Collect DUT events; event pulses must never overlap
   always @(negedge clk) begin : monitor
      int n;
      n = int'(key_valid) + int'(key_release) + int'(multi_key);
      if (n > 0) begin
         checkOutput("pulse_exclusive", n, 1);
         if (key_valid)   dut_q.push_back({4'd1, key_code});
         if (key_release) dut_q.push_back({4'd2, key_code});
         if (multi_key)   dut_q.push_back({4'd3, 4'd0});
      end
   end

   // Idle keypad: a single key is reported as pressed, several keys are rejected
   task automatic scanRule(input logic [15:0] v);
      int idx;
      if ($countones(v) == 1) begin
         idx = 0;
         for (int i = 0; i < 16; i++) if (v[i]) idx = i;
         held_key  = idx;
         last_code = idx;
         exp_q.push_back({4'd1, 4'(idx)});
      end else if ($countones(v) > 1) begin
         blocked = 1'b1;
         exp_q.push_back({4'd3, 4'd0});
      end
   endtask

   // Reference model: reaction to a key set that stays put long enough to debounce
   task automatic modelApply(input logic [15:0] v);
      logic [15:0] held_bits;
      if (held_key >= 0) begin
         held_bits = 16'(1) << held_key;
         if (v != held_bits) begin
            exp_q.push_back({4'd2, 4'(held_key)});
            held_key = -1;
            scanRule(v);
         end
      end else if (blocked) begin
         if (v == '0) blocked = 1'b0;
      end else begin
         scanRule(v);
      end
   endtask

   // Hold a key set for len clocks, then compare the events seen in that window
   task automatic applyStimulus(input logic [15:0] v, input int len);
      keys     = v;
      cur_keys = v;
      if (len >= LONG) modelApply(v);
      repeat (len) @(negedge clk);
      #1;
      checkOutput("event_count", dut_q.size(), exp_q.size());
      for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
         checkOutput("event", dut_q[i], exp_q[i]);
      end
      checkOutput("key_held", key_held, held_key >= 0);
      checkOutput("key_code", key_code, last_code);
      dut_q.delete();
      exp_q.delete();
   endtask

   function automatic logic [15:0] randKeys();
      int sel;
      int a;
      int b;
      logic [15:0] v;
      sel = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      v = '0;
      if (sel == 1 || sel == 2) v = 16'(1) << a;
      else if (sel == 3) v = (16'(1) << a) | (16'(1) << b);
      return v;
   endfunction

   initial begin
      logic [3:0]  exp_col;
      logic [15:0] v;
      int          len;

      // Reset state
      rst_n = 1'b0;
      keys  = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_columns", columns, 4'hF);
      checkOutput("rst_key_valid", key_valid, 0);
      checkOutput("rst_key_release", key_release, 0);
      checkOutput("rst_multi_key", multi_key, 0);
      checkOutput("rst_key_held", key_held, 0);
      checkOutput("rst_key_code", key_code, 0);
      rst_n = 1'b1;

      // Column walk: each column low for two clocks in turn
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         exp_col = ~(4'b0001 << ((k / 2) % 4));
         checkOutput("columns_walk", columns, exp_col);
      end
      dut_q.delete();

      // Clean press and release of row1/col2 (code 9)
      applyStimulus(16'(1) << 9, 200);
      applyStimulus('0, 200);

      // Bouncing key 0, then held steady
      for (int i = 0; i < 15; i++) applyStimulus((i % 2 == 0) ? 16'h0001 : 16'h0000, 20);
      applyStimulus(16'h0001, 200);
      applyStimulus('0, 200);

      // Two keys together are rejected and their release is silent
      applyStimulus((16'(1) << 1) | (16'(1) << 6), 200);
      applyStimulus('0, 200);

      // Slide from key 3 to key 7 without a gap
      applyStimulus(16'(1) << 3, 200);
      applyStimulus(16'(1) << 7, 250);
      applyStimulus('0, 200);

      // Reset while a key is held discards it silently
      applyStimulus(16'(1) << 5, 200);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("rst_hold_columns", columns, 4'hF);
      checkOutput("rst_hold_key_held", key_held, 0);
      checkOutput("rst_hold_key_code", key_code, 0);
      checkOutput("rst_hold_key_release", key_release, 0);
      keys     = '0;
      cur_keys = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkOutput("rst_hold_no_event", dut_q.size(), 0);
      dut_q.delete();
      held_key  = -1;
      blocked   = 1'b0;
      last_code = 0;

      // Random mix of glitches and debounced key sets
      for (int s = 0; s < 40; s++) begin
         do v = randKeys(); while (v == cur_keys);
         if ($urandom_range(0, 2) == 0) len = $urandom_range(3, 30);
         else len = $urandom_range(200, 280);
         applyStimulus(v, len);
      end
      applyStimulus('0, 250);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
